fwd_hazard_ctrl: RTL
====================

# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the 16-bit pipelined CPU. It tracks the destination registers of instructions in flight through EX, MEM and WB in its own shadow pipeline. It produces the registered 2-bit select codes that drive the operand-A and operand-B `mux4_1` forwarding muxes at the EX stage. It also raises a combinational stall for load-use hazards and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- `REG_ADDR_W`, 2: register address width (4 architectural registers).
- `CNT_W`, 16: width of the stall counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `id_valid` input 1: ID holds a real instruction.
- `id_rs` input REG_ADDR_W: source register A of the ID instruction.
- `id_rt` input REG_ADDR_W: source register B of the ID instruction.
- `id_use_rs` input 1: the ID instruction reads rs.
- `id_use_rt` input 1: the ID instruction reads rt.
- `id_rd` input REG_ADDR_W: destination register of the ID instruction.
- `id_reg_write` input 1: the ID instruction writes rd.
- `id_mem_read` input 1: the ID instruction is a load.
- `flush` input 1: kill the ID instruction (branch/jump redirect).
- `stall` output 1: combinational; freeze PC and IF/ID, insert a bubble into EX.
- `fwd_a` output 2: registered select for the operand-A `mux4_1`.
- `fwd_b` output 2: registered select for the operand-B `mux4_1`.
- `stall_count` output CNT_W: number of stall cycles, saturating.

## Operation
- Shadow records EX, MEM and WB, each holding {valid, rd, reg_write, mem_read}. All three advance every cycle: WB←MEM, MEM←EX, EX←(new entry).
- Match(stage, r): stage.valid & stage.reg_write & stage.rd==r.
- Load-use: `stall = id_valid & ~flush & EX.valid & EX.mem_read & EX.reg_write & ((id_use_rs & EX.rd==id_rs) | (id_use_rt & EX.rd==id_rt))`.
- Select encoding, evaluated against the records before the shift:
  - 0: register file.
  - 1: match in EX; the value comes from the EX/MEM ALU result next cycle.
  - 2: match in MEM; the value comes from MEM/WB.
  - 3: match in WB; the value comes from the held WB write data.
- Priority is 1 > 2 > 3 > 0 (the youngest producer wins). A select is nonzero only when the matching `id_use_*` is 1.
- New EX entry:
  - `flush`=1: bubble (valid=0); `fwd_a`/`fwd_b` ← 0.
  - `stall`=1: bubble; `fwd_a`/`fwd_b` ← 0.
  - Otherwise: {id_valid, id_rd, id_reg_write, id_mem_read}; `fwd_a`/`fwd_b` ← the computed selects, or 0 if `id_valid`=0.
- Flush and a potential stall in the same cycle: flush wins, `stall`=0, and no count is taken.
- `stall_count` increments on each cycle with `stall`=1 and holds at all-ones (0xFFFF).
- Register r0 gets no special treatment; it is forwarded like any other register.

## Timing
- Reset, asynchronous: all records go invalid (valid=0, fields 0), `fwd_a`=`fwd_b`=0, `stall_count`=0. `stall` is 0 during reset because EX is invalid. Deassertion is synchronised externally.
- `fwd_*` change only on a rising `clk` edge and are valid while the consumer occupies EX, one cycle after it was in ID.
- `stall` reflects the current inputs in the same cycle. A load-use stall lasts exactly one cycle: the load moves to MEM, and on the retry the select becomes 2.
- Reset asserted mid-stall clears everything immediately. The first cycle after reset shows no hazard.
- A held WB value means the datapath latches WB write data for one extra cycle; that latch is outside this block.

## Test plan
- Back-to-back ALU ops: add r1 then sub r2,r1,r3 → sub in EX has `fwd_a`=1, `fwd_b`=0, `stall` never high.
- Distance 2 and 3: producer r2, one independent op, then consumer of r2 → select 2. With two independent ops in between → select 3. With three in between → select 0.
- Priority: two consecutive writers of r1, then a reader of r1 → select 1, not 2.
- Load-use: lw r1 then add r2,r1,r1 → `stall`=1 for exactly 1 cycle. Next cycle `fwd_a`=`fwd_b`=2 and `stall_count` goes 0→1.
- Flush vs stall: the load-use condition with `flush`=1 → `stall`=0, the EX record is a bubble, `fwd_*`=0, and `stall_count` is unchanged. Preload the counter to 0xFFFF (via 65535 stalls or a forced value) and stall again → it stays 0xFFFF.
- Reset mid-operation: assert `reset` during a stall → `stall`, `fwd_a`, `fwd_b` and `stall_count` all 0 immediately. A consumer of r1 right after reset → select 0.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 16-bit pipelined CPU.
// Keeps a shadow EX/MEM/WB destination pipeline and emits registered mux4_1 selects.
`timescale 1ns/1ps

module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_count
);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } stage_rec_t;

  typedef enum logic [1:0] {
    SEL_RF  = 2'd0,
    SEL_EX  = 2'd1,
    SEL_MEM = 2'd2,
    SEL_WB  = 2'd3
  } fwd_sel_e;

  localparam stage_rec_t BUBBLE  = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_rec_t       ex_q,  ex_d;
  stage_rec_t       mem_q;
  stage_rec_t       wb_q;
  fwd_sel_e         fwd_a_q, fwd_a_d;
  fwd_sel_e         fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  function automatic logic produces(input stage_rec_t s, input reg_addr_t r);
    return s.valid & s.reg_write & (s.rd == r);
  endfunction

  // The youngest producer wins, so EX is tested before MEM before WB.
  function automatic fwd_sel_e pick_sel(input logic use_r, input reg_addr_t r,
                                        input stage_rec_t ex, input stage_rec_t mem,
                                        input stage_rec_t wb);
    if (!use_r)              return SEL_RF;
    else if (produces(ex, r))  return SEL_EX;
    else if (produces(mem, r)) return SEL_MEM;
    else if (produces(wb, r))  return SEL_WB;
    else                       return SEL_RF;
  endfunction

  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & ex_q.reg_write &
               ((id_use_rs & (ex_q.rd == id_rs)) | (id_use_rt & (ex_q.rd == id_rt)));
  end

  // A flush kills the consumer, so the hazard it would have caused never stalls.
  assign stall = id_valid & ~flush & load_use;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ex_d    = BUBBLE;
    fwd_a_d = SEL_RF;
    fwd_b_d = SEL_RF;
    cnt_d   = cnt_q;

    if (!flush && !stall) begin
      ex_d.valid     = id_valid;
      ex_d.rd        = id_rd;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      if (id_valid) begin
        fwd_a_d = pick_sel(id_use_rs, id_rs, ex_q, mem_q, wb_q);
        fwd_b_d = pick_sel(id_use_rt, id_rt, ex_q, mem_q, wb_q);
      end
    end

    if (stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign stall_count = cnt_q;

  // The WB load flag is carried for a uniform record but nothing downstream reads it.
  logic unused_wb_mem_read;
  assign unused_wb_mem_read = wb_q.mem_read;

endmodule
